// File: rtl/lattice_sync_fifo_pkg.sv
// Shared constants and helpers for the lattice synchronous FIFO.
package lattice_sync_fifo_pkg;

  // Read-mode selectors for the FWFT parameter
  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Ceiling log2, returns 0 for inputs of 0 or 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port single-clock RAM with registered read, shaped for block-RAM inference.
module sync_fifo_mem #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // Write port; array is never reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port with resettable output register (old data on same-address write)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/lattice_sync_fifo.sv
// Synchronous FIFO with standard or first-word-fall-through read mode.
module lattice_sync_fifo
  import lattice_sync_fifo_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned FWFT      = FIFO_STD,
  parameter int unsigned AF_THRESH = (1 << AW) - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] data_in,
  input  logic          rd_en,
  output logic [DW-1:0] data_out,
  output logic          valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned   CW      = AW + 1;
  localparam int unsigned   DEPTH   = 1 << AW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam bit            IS_FWFT = (FWFT == FIFO_FWFT);

  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_valid;
  logic          r_overflow;
  logic          r_underflow;
  logic          r_use_byp;
  logic [DW-1:0] r_byp;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [CW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_ram_re;
  logic [AW-1:0] w_ram_raddr;
  logic          w_byp_hit;
  logic [DW-1:0] w_ram_q;

  // Accept decisions, next pointers and RAM read control.
  // In FWFT mode the RAM continuously reads the next head; when that head is
  // being written on the same edge the RAM returns stale data, so the incoming
  // word is captured into a bypass register instead.
  always_comb begin
    w_wr_acc     = wr_en && !r_full;
    w_rd_acc     = rd_en && !r_empty;
    w_wr_ptr_nxt = r_wr_ptr + CW'(w_wr_acc);
    w_rd_ptr_nxt = r_rd_ptr + CW'(w_rd_acc);
    w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_ram_re     = w_rd_acc;
    w_ram_raddr  = r_rd_ptr[AW-1:0];
    w_byp_hit    = 1'b0;
    if (IS_FWFT) begin
      w_ram_re    = (w_count_nxt != '0);
      w_ram_raddr = w_rd_ptr_nxt[AW-1:0];
      w_byp_hit   = w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt);
    end
  end

  // Pointer, occupancy, flag and bypass state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_use_byp   <= 1'b0;
      r_byp       <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH_C);
      r_empty  <= (w_count_nxt == '0);
      r_valid  <= IS_FWFT ? (w_count_nxt != '0) : w_rd_acc;
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && r_empty) begin
        r_underflow <= 1'b1;
      end
      if (w_ram_re) begin
        r_use_byp <= w_byp_hit;
        if (w_byp_hit) begin
          r_byp <= data_in;
        end
      end
    end
  end

  sync_fifo_mem #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_wr_acc),
    .i_waddr(r_wr_ptr[AW-1:0]),
    .i_wdata(data_in),
    .i_re   (w_ram_re),
    .i_raddr(w_ram_raddr),
    .o_rdata(w_ram_q)
  );

  assign data_out     = r_use_byp ? r_byp : w_ram_q;
  assign valid        = r_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);

endmodule

// File: tb/tb_lattice_sync_fifo.sv
// Scoreboard bench for lattice_sync_fifo: one standard-mode and one FWFT instance, AW=4.
module tb_lattice_sync_fifo;

  logic       clk;
  logic       reset;

  logic       a_wr_en, a_rd_en;
  logic [7:0] a_din, a_dout;
  logic       a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_count;

  logic       b_wr_en, b_rd_en;
  logic [7:0] b_din, b_dout;
  logic       b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [4:0] b_count;

  int n_tests;
  int n_fail;
  bit mon_en;

  logic [7:0] qa [$];
  logic [7:0] qb [$];

  lattice_sync_fifo #(.AW(4), .DW(8), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) u_dut_std (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .data_in(a_din), .rd_en(a_rd_en),
    .data_out(a_dout), .valid(a_valid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf)
  );

  lattice_sync_fifo #(.AW(4), .DW(8), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) u_dut_fwft (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .data_in(b_din), .rd_en(b_rd_en),
    .data_out(b_dout), .valid(b_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Standard-mode monitor: every valid pulse must carry the next expected word
  always @(negedge clk) begin
    if (mon_en && a_valid === 1'b1) begin
      n_tests++;
      if (qa.size() == 0) begin
        n_fail++;
        $display("FAIL std_unexpected_valid: got 0x%0h expected no output", a_dout);
      end else begin
        logic [7:0] e;
        e = qa.pop_front();
        if (a_dout !== e) begin
          n_fail++;
          $display("FAIL std_data: got 0x%0h expected 0x%0h at %0t", a_dout, e, $time);
        end
      end
    end
  end

  // FWFT monitor: compare head on each pop, and keep valid tied to !empty
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (b_valid !== !b_empty) begin
        n_fail++;
        $display("FAIL fwft_valid_vs_empty: valid %b empty %b at %0t", b_valid, b_empty, $time);
      end
      if (b_rd_en === 1'b1 && b_valid === 1'b1) begin
        n_tests++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL fwft_unexpected_pop: got 0x%0h expected no data", b_dout);
        end else begin
          logic [7:0] e;
          e = qb.pop_front();
          if (b_dout !== e) begin
            n_fail++;
            $display("FAIL fwft_data: got 0x%0h expected 0x%0h at %0t", b_dout, e, $time);
          end
        end
      end
    end
  end

  initial begin
    int k;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    reset   = 1'b1;
    a_wr_en = 1'b1; a_rd_en = 1'b1; a_din = 8'hFF;
    b_wr_en = 1'b1; b_rd_en = 1'b1; b_din = 8'hFF;

    // Reset with requests active: requests must be ignored, no error flags
    tick();
    tick();
    reset = 1'b0;
    a_wr_en = 1'b0; a_rd_en = 1'b0;
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    mon_en = 1'b1;
    check32("rst_count", 32'(a_count), 32'd0);
    check1("rst_empty", a_empty, 1'b1);
    check1("rst_full", a_full, 1'b0);
    check1("rst_ae", a_ae, 1'b1);
    check1("rst_af", a_af, 1'b0);
    check1("rst_valid", a_valid, 1'b0);
    check1("rst_ovf", a_ovf, 1'b0);
    check1("rst_unf", a_unf, 1'b0);
    check32("rst_dout", 32'(a_dout), 32'd0);
    check1("rst_fwft_valid", b_valid, 1'b0);
    check1("rst_fwft_empty", b_empty, 1'b1);

    // Fill 0x01..0x10, tracking thresholds
    for (int i = 1; i <= 16; i++) begin
      a_wr_en = 1'b1;
      a_din   = 8'(i);
      qa.push_back(8'(i));
      tick();
      check32("fill_count", 32'(a_count), 32'(i));
      check1("fill_af", a_af, (i >= 14));
      check1("fill_ae", a_ae, (i <= 2));
    end
    check1("fill_full", a_full, 1'b1);
    check1("fill_empty", a_empty, 1'b0);

    // Write into full FIFO is dropped
    a_din = 8'h11;
    tick();
    a_wr_en = 1'b0;
    check1("ovf_set", a_ovf, 1'b1);
    check32("ovf_count", 32'(a_count), 32'd16);
    check1("ovf_full", a_full, 1'b1);

    // Drain 16 words; monitor checks order and one-cycle latency
    a_rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check32("drain_count", 32'(a_count), 32'(16 - i));
    end
    a_rd_en = 1'b0;
    tick();
    check1("drain_empty", a_empty, 1'b1);
    check1("drain_unf_clear", a_unf, 1'b0);

    // Extra read on empty FIFO
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    check1("unf_set", a_unf, 1'b1);
    check1("unf_empty", a_empty, 1'b1);
    check1("unf_valid", a_valid, 1'b0);
    check32("unf_dout_hold", 32'(a_dout), 32'h10);

    // Reset clears sticky flags
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("rst2_ovf", a_ovf, 1'b0);
    check1("rst2_unf", a_unf, 1'b0);

    // Count 8 then 20 cycles of simultaneous read/write with pointer wrap
    a_wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_din = 8'(8'h20 + i);
      qa.push_back(8'(8'h20 + i));
      tick();
    end
    a_rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_din = 8'(8'h28 + i);
      qa.push_back(8'(8'h28 + i));
      tick();
      check32("simul_count", 32'(a_count), 32'd8);
    end
    a_wr_en = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    a_rd_en = 1'b0;
    tick();
    check1("simul_empty", a_empty, 1'b1);
    check32("simul_queue_drained", 32'(qa.size()), 32'd0);

    // Full FIFO with simultaneous read and write: read taken, write dropped
    a_wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_din = 8'(8'h40 + i);
      qa.push_back(8'(8'h40 + i));
      tick();
    end
    a_din   = 8'hEE;
    a_rd_en = 1'b1;
    tick();
    a_wr_en = 1'b0;
    check32("fullrw_count", 32'(a_count), 32'd15);
    check1("fullrw_ovf", a_ovf, 1'b1);
    check1("fullrw_full", a_full, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    a_rd_en = 1'b0;
    check32("pre_reset_count", 32'(a_count), 32'd10);

    // Reset with 10 words stored discards them
    reset = 1'b1;
    tick();
    reset = 1'b0;
    qa.delete();
    qb.delete();
    check32("midrst_count", 32'(a_count), 32'd0);
    check1("midrst_empty", a_empty, 1'b1);
    check1("midrst_valid", a_valid, 1'b0);
    check1("midrst_ovf", a_ovf, 1'b0);
    check1("midrst_unf", a_unf, 1'b0);
    check1("midrst_full", a_full, 1'b0);
    check1("midrst_ae", a_ae, 1'b1);

    // FWFT: single word into empty FIFO appears within two cycles
    b_wr_en = 1'b1;
    b_din   = 8'hA5;
    qb.push_back(8'hA5);
    tick();
    b_wr_en = 1'b0;
    k = 0;
    while (b_valid !== 1'b1 && k < 2) begin
      tick();
      k++;
    end
    check1("fwft_valid_latency", b_valid, 1'b1);
    check32("fwft_head", 32'(b_dout), 32'hA5);
    check1("fwft_not_empty", b_empty, 1'b0);
    b_rd_en = 1'b1;
    tick();
    b_rd_en = 1'b0;
    check1("fwft_pop_valid", b_valid, 1'b0);
    check1("fwft_pop_empty", b_empty, 1'b1);
    check32("fwft_pop_count", 32'(b_count), 32'd0);

    // FWFT back-to-back pops
    b_wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_din = 8'(8'hB0 + i);
      qb.push_back(8'(8'hB0 + i));
      tick();
    end
    b_wr_en = 1'b0;
    check32("fwft_b2b_head", 32'(b_dout), 32'hB0);
    b_rd_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    b_rd_en = 1'b0;
    check1("fwft_b2b_empty", b_empty, 1'b1);

    // FWFT with one word: pop and write on the same edge replaces the head
    b_wr_en = 1'b1;
    b_din   = 8'hC0;
    qb.push_back(8'hC0);
    tick();
    b_rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      b_din = 8'(8'hC0 + i);
      qb.push_back(8'(8'hC0 + i));
      tick();
      check32("fwft_c1_count", 32'(b_count), 32'd1);
      check32("fwft_c1_head", 32'(b_dout), 32'(8'hC0 + i));
    end
    b_wr_en = 1'b0;
    tick();
    b_rd_en = 1'b0;
    tick();
    check1("fwft_c1_empty", b_empty, 1'b1);
    check32("fwft_queue_drained", 32'(qb.size()), 32'd0);
    check32("std_queue_drained", 32'(qa.size()), 32'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
